mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit in the EX stage, alongside the ALU. It is fed from the same ID/EX operand path, after forwarding. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. While an operation is in flight it raises a stall request that freezes the upstream pipeline. An exception flush from the exception logic cancels the operation.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  valid mul/div/move request from ID/EX
- op  in  3  3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
- opa  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- opb  in  32  rt operand (divisor / multiplier)
- flush  in  1  cancel in-flight op, exception taken
- busy  out  1  stall request to pipeline control (combinational)
- done  out  1  one-cycle pulse, HI/LO valid with new result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States:
  - IDLE: accepts start.
  - RUN: 32 iterations.
  - DONE: result presented.
- Transitions from IDLE:
  - start with MULT/MULTU/DIV/DIVU: go to RUN; load abs(opa) and abs(opb); signed ops record sign flags.
  - DIV/DIVU with opb==0: skip RUN, go to DONE; hi<=opa, lo<=32'hFFFFFFFF.
  - MTHI: hi<=opa at the next edge, stay IDLE, no busy, no done. MTLO likewise writes lo.
- RUN:
  - Iteration counter 0..31.
  - Divide: restoring radix-2, one quotient bit per cycle, 33-bit partial remainder.
  - Multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
  - After iteration 31, go to DONE; hi/lo are written on that edge.
- Sign fix-up, applied when writing hi/lo:
  - Product: negate the 64-bit value if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Divide results: lo=quotient, hi=remainder. Multiply results: {hi,lo}=product.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap). No exception.
- DONE: done=1, busy=0; start is ignored; always returns to IDLE next edge. The stalled instruction proceeds in this cycle, so it must not be re-issued.
- busy = (state==RUN) | (state==IDLE & start & ~flush & op is MULT/MULTU/DIV/DIVU).
- flush:
  - Highest priority after rst, in any state.
  - Next state is IDLE; hi/lo are left unchanged and done is not pulsed.
  - flush together with start (any op, including MTHI/MTLO) suppresses the start.
- rst: state=IDLE, hi=0, lo=0, counter=0; busy=0, done=0 from the cycle after rst is sampled high. rst mid-RUN aborts the operation.

## Timing
- MTHI/MTLO: 1 cycle, value visible the cycle after start, zero stall.
- Multi-cycle mul/div:
  - Start is cycle 0: busy=1 in cycles 0..32, done=1 in cycle 33.
  - New hi/lo are visible from cycle 33.
  - Total stall is 33 cycles.
- Divide by zero: busy=1 in cycle 0 only; done and result in cycle 1.
- hi/lo change only on the edge entering DONE, or on an MTHI/MTLO edge.
- A new start is accepted no earlier than the IDLE cycle after DONE (back-to-back ops: cycle 34).

## Configuration
- MDU_FAST_MULT_EN defined:
  - MULT/MULTU use a single-cycle 32x32 multiplier and skip RUN (IDLE -> DONE).
  - busy=1 in cycle 0 only; done and result in cycle 1.
  - DIV/DIVU are unchanged.
- Not defined: multiply is iterative, with the 33-cycle timing above.

## Test plan
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> busy high 33 cycles; done in cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Done in cycle 33, or cycle 1 with MDU_FAST_MULT_EN.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opa=0x1234, opb=0 -> done in cycle 1, hi=0x00001234, lo=0xFFFFFFFF, busy only in cycle 0.
- Preload hi=lo=0xA5A5A5A5. Then:
  - DIV started, flush at RUN cycle 10 -> busy=0 next cycle, no done, hi/lo still 0xA5A5A5A5.
  - Then MTHI 0x12345678 -> hi=0x12345678 next cycle, lo unchanged.
- rst asserted at RUN cycle 20 of MULTU -> next cycle busy=0, done=0, hi=lo=0; following DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MDU_FAST_MULT_EN for a single-cycle 32x32 multiplier; divide always iterates.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [31:0] r_opd;
    logic [63:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_md;
    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_is_md  = ~op[2];
    assign w_signed = (op == OP_MULT) | (op == OP_DIV);
    assign w_abs_a  = (w_signed & opa[31]) ? -opa : opa;
    assign w_abs_b  = (w_signed & opb[31]) ? -opb : opb;

    // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: dividend shifts out of acc[31:0] while quotient bits shift in.
    assign w_div_sh   = {r_rem, r_acc[31]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_opd});
    assign w_rem_next = w_div_ge ? (w_div_sh[31:0] - r_opd) : w_div_sh[31:0];
    assign w_quo_next = {r_acc[30:0], w_div_ge};

    assign w_prod    = r_neg_res ? -w_mul_next : w_mul_next;
    assign w_quo_fix = r_neg_res ? -w_quo_next : w_quo_next;
    assign w_rem_fix = r_neg_rem ? -w_rem_next : w_rem_next;

`ifdef MDU_FAST_MULT_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = (op == OP_MULT)
        ? 64'($signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb}))
        : ({32'd0, opa} * {32'd0, opb});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opd     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: r_hi <= opa;
                            OP_MTLO: r_lo <= opa;
                            OP_DIV, OP_DIVU: begin
                                if (opb == '0) begin
                                    r_hi    <= opa;
                                    r_lo    <= '1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_is_div  <= 1'b1;
                                    r_neg_res <= w_signed & (opa[31] ^ opb[31]);
                                    r_neg_rem <= w_signed & opa[31];
                                    r_opd     <= w_abs_b;
                                    r_acc     <= {32'd0, w_abs_a};
                                    r_rem     <= '0;
                                    r_cnt     <= '0;
                                    r_state   <= S_RUN;
                                end
                            end
                            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                                {r_hi, r_lo} <= w_fast_prod;
                                r_state      <= S_DONE;
`else
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_signed & (opa[31] ^ opb[31]);
                                r_neg_rem <= 1'b0;
                                r_opd     <= w_abs_a;
                                r_acc     <= {32'd0, w_abs_b};
                                r_rem     <= '0;
                                r_cnt     <= '0;
                                r_state   <= S_RUN;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= {r_acc[63:32], w_quo_next};
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 5'd1;
                    // Last iteration: write the sign-corrected result straight from the step logic.
                    if (r_cnt == 5'd31) begin
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN) | ((r_state == S_IDLE) & start & ~flush & w_is_md);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Architectural result of one request, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        eh  = m_hi;
        el  = m_lo;
        lat = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            3'd0: begin {eh, el} = sa * sb; lat = FAST ? 1 : 33; end
            3'd1: begin {eh, el} = ua * ub; lat = FAST ? 1 : 33; end
            3'd2: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; lat = 1; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; lat = 33; end
            end
            3'd3: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; lat = 1; end
                else begin el = 32'(ua / ub); eh = 32'(ua % ub); lat = 33; end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [31:0] eh, el;
        int          lat;
        model(o, a, b, eh, el, lat);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        #1;
        check("busy_c0", 64'(busy), 64'(lat > 0));
        check("done_c0", 64'(done), 64'(0));
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom;
        #1;
        if (lat == 0) begin
            check("mv_hi", 64'(hi), 64'(eh));
            check("mv_lo", 64'(lo), 64'(el));
            check("mv_busy", 64'(busy), 64'(0));
            check("mv_done", 64'(done), 64'(0));
        end else begin
            for (int c = 1; c < lat; c++) begin
                check("run_busy", 64'(busy), 64'(1));
                check("run_done", 64'(done), 64'(0));
                check("run_hi_hold", 64'(hi), 64'(m_hi));
                @(negedge clk);
                #1;
            end
            check("res_done", 64'(done), 64'(1));
            check("res_busy", 64'(busy), 64'(0));
            check("res_hi", 64'(hi), 64'(eh));
            check("res_lo", 64'(lo), 64'(el));
            if (poke) begin
                start = 1'b1; op = 3'd4; opa = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            check("post_done", 64'(done), 64'(0));
            check("post_busy", 64'(busy), 64'(0));
            check("post_hi", 64'(hi), 64'(eh));
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd3, 32'h0000_1234, 32'd0, 1'b1);
        run_op(3'd2, 32'd17, 32'hFFFF_FFFB, 1'b0);

        // Flush mid-divide leaves HI/LO untouched and suppresses done.
        run_op(3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
        run_op(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("fl_busy_c10", 64'(busy), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy", 64'(busy), 64'(0));
        check("fl_done", 64'(done), 64'(0));
        check("fl_hi", 64'(hi), 64'(32'hA5A5_A5A5));
        check("fl_lo", 64'(lo), 64'(32'hA5A5_A5A5));
        repeat (3) begin
            @(negedge clk);
            #1;
            check("fl_no_done", 64'(done), 64'(0));
        end
        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_lo_keep", 64'(lo), 64'(32'hA5A5_A5A5));

        // Flush alongside start cancels both multi-cycle and move requests.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; opa = 32'd7; opb = 32'd9;
        #1;
        check("flst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        op = 3'd5; opa = 32'hDEAD_BEEF;
        #1;
        check("flst_done", 64'(done), 64'(0));
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flst_hi", 64'(hi), 64'(m_hi));
        check("flst_lo", 64'(lo), 64'(m_lo));
        check("flst_busy2", 64'(busy), 64'(0));

        // Reset in the middle of a MULTU.
        @(negedge clk);
        start = 1'b1; op = 3'd1; opa = 32'hCAFE_0001; opb = 32'h0000_7777;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_done", 64'(done), 64'(0));
        check("mrst_hi", 64'(hi), 64'(0));
        check("mrst_lo", 64'(lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        run_op(3'd3, 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = {{28{rb[31]}}, rb[3:0]};
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
